// File: rtl/bsg_gray_pkg.sv
// rtl/bsg_gray_pkg.sv - shared Gray/binary conversion helpers
// Functions operate on a maximum-width vector; callers zero-extend their
// operands in and size-cast the result back to their own pointer width.
package bsg_gray_pkg;

  localparam int gray_max_width_lp = 32;

  typedef logic [gray_max_width_lp-1:0] gray_max_t;

  localparam int err_step_bit_lp = 0;  // illegal pointer step
  localparam int err_yumi_bit_lp = 1;  // yumi while empty

  function automatic gray_max_t bin2gray(input gray_max_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero-extended inputs keep the upper bits zero, so the prefix XOR over
  // the full vector gives the right answer for any narrower width.
  function automatic gray_max_t gray2bin(input gray_max_t gray);
    gray_max_t bin;
    bin[gray_max_width_lp-1] = gray[gray_max_width_lp-1];
    for (int i = gray_max_width_lp - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/bsg_sync_gray_ptr_rx_if.sv
// rtl/bsg_sync_gray_ptr_rx_if.sv - pointer-receive bundle between synchronizer, consumer and rx block
// slave  (rx block): gray_ptr_i, yumi_i in; v_o, count_o, rptr_o, rptr_gray_o, err_o out
// master (environment): the mirror image
interface bsg_sync_gray_ptr_rx_if #(parameter int width_p = 8);

  logic [width_p-1:0] gray_ptr_i;
  logic               yumi_i;
  logic               v_o;
  logic [width_p-1:0] count_o;
  logic [width_p-1:0] rptr_o;
  logic [width_p-1:0] rptr_gray_o;
  logic [1:0]         err_o;

  modport slave (
    input  gray_ptr_i, yumi_i,
    output v_o, count_o, rptr_o, rptr_gray_o, err_o
  );

  modport master (
    output gray_ptr_i, yumi_i,
    input  v_o, count_o, rptr_o, rptr_gray_o, err_o
  );

endinterface

// File: rtl/bsg_gray_to_binary.sv
// rtl/bsg_gray_to_binary.sv - combinational Gray-to-binary prefix XOR
// Ports: gray_i (Gray code in), binary_o (binary equivalent out)
module bsg_gray_to_binary #(
  parameter int width_p = 8
) (
  input  logic [width_p-1:0] gray_i,
  output logic [width_p-1:0] binary_o
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    binary_o = '0;
    binary_o[width_p-1] = gray_i[width_p-1];
    for (int i = width_p - 2; i >= 0; i--) begin
      binary_o[i] = binary_o[i+1] ^ gray_i[i];
    end
  end

endmodule

// File: rtl/bsg_sync_gray_ptr_rx.sv
// rtl/bsg_sync_gray_ptr_rx.sv - receive-side Gray pointer consumer with valid/yumi
// Ports: clk_i (synchronizer output-domain clock), reset_n_i (async, active-low),
//        bus (slave modport: gray_ptr_i, yumi_i in; v_o, count_o, rptr_o,
//        rptr_gray_o, err_o out)
module bsg_sync_gray_ptr_rx #(
  parameter int width_p    = 8,
  parameter int max_step_p = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  bsg_sync_gray_ptr_rx_if.slave   bus
);

  import bsg_gray_pkg::*;

  localparam logic [width_p-1:0] max_step_lp = width_p'(max_step_p);

  logic [width_p-1:0] wptr_r, rptr_r, rgray_r;
  logic [1:0]         err_r;

  logic [width_p-1:0] wptr_n, step, count, rptr_inc, rgray_next;
  logic               step_ok, v;

  bsg_gray_to_binary #(.width_p(width_p)) g2b (
    .gray_i   (bus.gray_ptr_i),
    .binary_o (wptr_n)
  );

  // Modulo subtraction: a backward move shows up as a huge forward step,
  // so one unsigned compare catches both jumps and reversals.
  assign step     = wptr_n - wptr_r;
  assign step_ok  = (step <= max_step_lp);
  assign count    = wptr_r - rptr_r;
  assign v        = (count != '0);
  assign rptr_inc = rptr_r + 1'b1;
  assign rgray_next = width_p'(bin2gray(gray_max_t'(rptr_inc)));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      rgray_r <= '0;
      err_r   <= '0;
    end else begin
      if (step_ok) begin
        wptr_r <= wptr_n;
      end else begin
        err_r[err_step_bit_lp] <= 1'b1;
      end

      if (bus.yumi_i) begin
        if (v) begin
          rptr_r  <= rptr_inc;
          rgray_r <= rgray_next;
        end else begin
          err_r[err_yumi_bit_lp] <= 1'b1;
        end
      end
    end
  end

  assign bus.v_o         = v;
  assign bus.count_o     = count;
  assign bus.rptr_o      = rptr_r;
  assign bus.rptr_gray_o = rgray_r;
  assign bus.err_o       = err_r;

endmodule

// File: tb/tb_bsg_sync_gray_ptr_rx.sv
// tb/tb_bsg_sync_gray_ptr_rx.sv - self-checking bench for bsg_sync_gray_ptr_rx
module tb_bsg_sync_gray_ptr_rx;

  localparam int W    = 8;
  localparam int MOD  = 256;
  localparam int MAXS = 4;

  logic clk;
  logic rst_n;

  bsg_sync_gray_ptr_rx_if #(.width_p(W)) bus ();

  bsg_sync_gray_ptr_rx #(.width_p(W), .max_step_p(MAXS)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference model: pointers as plain integers modulo 256.
  int m_w, m_r;
  logic [1:0] m_err;

  function automatic logic [W-1:0] to_gray(input int b);
    int g;
    g = b ^ (b >> 1);
    return g[W-1:0];
  endfunction

  function automatic int m_count();
    return (m_w - m_r + MOD) % MOD;
  endfunction

  // Present a binary write pointer (as Gray) and yumi, cross one edge,
  // apply the rules to the model, then settle 1 time unit past the edge.
  task automatic drive_cycle(input int wb, input logic y);
    int st, cnt;
    bus.gray_ptr_i = to_gray(wb);
    bus.yumi_i     = y;
    @(posedge clk);
    st  = (wb - m_w + MOD) % MOD;
    cnt = m_count();
    if (st <= MAXS) m_w = wb % MOD;
    else m_err[0] = 1'b1;
    if (y) begin
      if (cnt != 0) m_r = (m_r + 1) % MOD;
      else m_err[1] = 1'b1;
    end
    #1;
  endtask

  task automatic apply_reset();
    bus.gray_ptr_i = '0;
    bus.yumi_i     = 1'b0;
    rst_n = 1'b0;
    m_w = 0; m_r = 0; m_err = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (bus.v_o !== 1'b0) begin miscompares++; $display("FAIL reset_v got %0h expected 0", bus.v_o); end
    vectors++; if (bus.count_o !== 8'h00) begin miscompares++; $display("FAIL reset_count got %0h expected 0", bus.count_o); end
    vectors++; if (bus.rptr_o !== 8'h00) begin miscompares++; $display("FAIL reset_rptr got %0h expected 0", bus.rptr_o); end
    vectors++; if (bus.rptr_gray_o !== 8'h00) begin miscompares++; $display("FAIL reset_rgray got %0h expected 0", bus.rptr_gray_o); end
    vectors++; if (bus.err_o !== 2'b00) begin miscompares++; $display("FAIL reset_err got %0h expected 0", bus.err_o); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 3; i++) begin
      drive_cycle(i, 1'b0);
      vectors++; if (bus.count_o !== 8'(i)) begin miscompares++; $display("FAIL fill_count got %0d expected %0d", bus.count_o, i); end
      vectors++; if (bus.v_o !== 1'b1) begin miscompares++; $display("FAIL fill_v got %0h expected 1", bus.v_o); end
      vectors++; if (bus.err_o !== 2'b00) begin miscompares++; $display("FAIL fill_err got %0h expected 0", bus.err_o); end
    end
  endtask

  task automatic test_drain();
    logic [7:0] exp_gray [3];
    exp_gray[0] = 8'h01; exp_gray[1] = 8'h03; exp_gray[2] = 8'h02;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(3, 1'b1);
      vectors++; if (bus.count_o !== 8'(2 - i)) begin miscompares++; $display("FAIL drain_count got %0d expected %0d", bus.count_o, 2 - i); end
      vectors++; if (bus.rptr_o !== 8'(i + 1)) begin miscompares++; $display("FAIL drain_rptr got %0h expected %0h", bus.rptr_o, i + 1); end
      vectors++; if (bus.rptr_gray_o !== exp_gray[i]) begin miscompares++; $display("FAIL drain_rgray got %0h expected %0h", bus.rptr_gray_o, exp_gray[i]); end
      vectors++; if (bus.v_o !== (i != 2)) begin miscompares++; $display("FAIL drain_v got %0h expected %0h", bus.v_o, (i != 2)); end
    end
  endtask

  task automatic test_wrap();
    int w, st;
    bit saw_wrap;
    logic [7:0] prev_r;
    w = m_w;
    // Walk both pointers up to 0xFE one entry at a time.
    while (w != 8'hFE) begin
      w = (w + 1) % MOD;
      drive_cycle(w, m_count() != 0);
    end
    while (m_count() != 0) drive_cycle(w, 1'b1);
    vectors++; if (bus.rptr_o !== 8'hFE || bus.count_o !== 8'h00) begin miscompares++; $display("FAIL wrap_preset got rptr %0h count %0h expected fe 0", bus.rptr_o, bus.count_o); end
    saw_wrap = 0;
    prev_r = bus.rptr_o;
    // Advance to 0x01 in random steps while consuming every valid cycle.
    while (w != 1 || m_count() != 0) begin
      st = (w == 1) ? 0 : $urandom_range(1, MAXS);
      if (st > ((1 - w + MOD) % MOD)) st = (1 - w + MOD) % MOD;
      w = (w + st) % MOD;
      drive_cycle(w, bus.v_o);
      vectors++; if (bus.count_o !== 8'(m_count()) || m_count() > MAXS) begin miscompares++; $display("FAIL wrap_count got %0d expected %0d (step %0d)", bus.count_o, m_count(), st); end
      vectors++; if (bus.rptr_o !== 8'(m_r) || bus.rptr_gray_o !== to_gray(m_r)) begin miscompares++; $display("FAIL wrap_rptr got %0h/%0h expected %0h/%0h", bus.rptr_o, bus.rptr_gray_o, m_r, to_gray(m_r)); end
      if (prev_r == 8'hFF && bus.rptr_o == 8'h00) saw_wrap = 1;
      prev_r = bus.rptr_o;
    end
    vectors++; if (!saw_wrap) begin miscompares++; $display("FAIL wrap_seen got 0 expected 1"); end
    vectors++; if (bus.err_o !== 2'b00) begin miscompares++; $display("FAIL wrap_err got %0h expected 0", bus.err_o); end
  endtask

  task automatic test_same_cycle();
    int w;
    w = m_w;
    drive_cycle((w + 1) % MOD, 1'b0);
    vectors++; if (bus.count_o !== 8'd1) begin miscompares++; $display("FAIL same_pre got %0d expected 1", bus.count_o); end
    drive_cycle((w + 3) % MOD, 1'b1);
    vectors++; if (bus.count_o !== 8'd2) begin miscompares++; $display("FAIL same_count got %0d expected 2", bus.count_o); end
    vectors++; if (bus.rptr_o !== 8'(m_r)) begin miscompares++; $display("FAIL same_rptr got %0h expected %0h", bus.rptr_o, m_r); end
  endtask

  task automatic test_random();
    int w;
    logic y;
    w = m_w;
    for (int i = 0; i < 300; i++) begin
      w = (w + $urandom_range(0, MAXS)) % MOD;
      y = (m_count() != 0) && ($urandom_range(0, 3) != 0);
      drive_cycle(w, y);
      vectors++;
      if (bus.count_o !== 8'(m_count()) || bus.v_o !== (m_count() != 0) ||
          bus.rptr_o !== 8'(m_r) || bus.rptr_gray_o !== to_gray(m_r) || bus.err_o !== m_err) begin
        miscompares++;
        $display("FAIL random cyc %0d got cnt %0d v %0h r %0h g %0h e %0h expected cnt %0d r %0h g %0h e %0h",
                 i, bus.count_o, bus.v_o, bus.rptr_o, bus.rptr_gray_o, bus.err_o,
                 m_count(), m_r, to_gray(m_r), m_err);
      end
    end
  endtask

  task automatic test_illegal_step();
    apply_reset();
    for (int i = 1; i <= 5; i++) drive_cycle(i, 1'b0);
    drive_cycle(20, 1'b0);
    vectors++; if (bus.err_o[0] !== 1'b1) begin miscompares++; $display("FAIL illegal_err got %0h expected 1", bus.err_o[0]); end
    vectors++; if (bus.count_o !== 8'd5) begin miscompares++; $display("FAIL illegal_count got %0d expected 5", bus.count_o); end
    // Back to a legal pointer: error stays sticky and consumption still works.
    drive_cycle(5, 1'b1);
    drive_cycle(6, 1'b0);
    vectors++; if (bus.err_o !== 2'b01) begin miscompares++; $display("FAIL illegal_sticky got %0h expected 1", bus.err_o); end
    vectors++; if (bus.count_o !== 8'd5 || bus.rptr_o !== 8'd1) begin miscompares++; $display("FAIL illegal_after got cnt %0d r %0h expected 5 1", bus.count_o, bus.rptr_o); end
    // A backward move is also an illegal step.
    drive_cycle(4, 1'b0);
    vectors++; if (bus.count_o !== 8'd5) begin miscompares++; $display("FAIL backward_count got %0d expected 5", bus.count_o); end
    apply_reset();
    vectors++; if (bus.err_o !== 2'b00) begin miscompares++; $display("FAIL illegal_clear got %0h expected 0", bus.err_o); end
  endtask

  task automatic test_yumi_empty();
    apply_reset();
    drive_cycle(0, 1'b1);
    vectors++; if (bus.err_o !== 2'b10) begin miscompares++; $display("FAIL yumi_empty_err got %0h expected 2", bus.err_o); end
    vectors++; if (bus.rptr_o !== 8'h00) begin miscompares++; $display("FAIL yumi_empty_rptr got %0h expected 0", bus.rptr_o); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 1; i <= 4; i++) drive_cycle(i, i > 2);
    drive_cycle(5, 1'b1);
    drive_cycle(9, 1'b0);
    // Assert reset mid-cycle and look before the next rising edge.
    rst_n = 1'b0;
    m_w = 0; m_r = 0; m_err = 2'b00;
    #1;
    vectors++;
    if (bus.v_o !== 1'b0 || bus.count_o !== 8'h00 || bus.rptr_o !== 8'h00 ||
        bus.rptr_gray_o !== 8'h00 || bus.err_o !== 2'b00) begin
      miscompares++;
      $display("FAIL async_reset got v %0h cnt %0h r %0h g %0h e %0h expected all 0",
               bus.v_o, bus.count_o, bus.rptr_o, bus.rptr_gray_o, bus.err_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_cycle(3, 1'b0);
    vectors++; if (bus.count_o !== 8'd3 || bus.err_o !== 2'b00) begin miscompares++; $display("FAIL post_reset_legal got cnt %0d e %0h expected 3 0", bus.count_o, bus.err_o); end
    apply_reset();
    drive_cycle(9, 1'b0);
    vectors++; if (bus.count_o !== 8'd0 || bus.err_o !== 2'b01) begin miscompares++; $display("FAIL post_reset_jump got cnt %0d e %0h expected 0 1", bus.count_o, bus.err_o); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.gray_ptr_i = '0;
    bus.yumi_i = 1'b0;
    m_w = 0; m_r = 0; m_err = 2'b00;
    @(posedge clk); #1;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_same_cycle();
    test_random();
    test_illegal_step();
    test_yumi_empty();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
